keypad_row_scanner: RTL and testbench

// Drives the row strobes of the 4x4 matrix keypad and reads back its column returns.

---
 rtl/keypad_row_scanner.sv | 257 +++++++++++++++++++++++++
 tb/tb_keypad_row_scanner.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner
// Scans a 4x4 matrix keypad one row at a time, synchronises and debounces the
// column returns, and reports a single accepted key as a one-cycle press event
// plus a held level. key_raw uses the active-low {col,row} byte that the
// keypad-to-HEX decoder expects, so it can be wired straight into that decoder.
//
// Parameters
//   SCAN_DIV        clock cycles each row is strobed (>= 4)
//   DEBOUNCE_SCANS  consecutive full scans needed to accept a press or release (>= 1)
//
// Ports
//   CLOCK_50     in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high
//   col_n        in   4  column returns, active-low, externally pulled up
//   row_n        out  4  row strobes, exactly one bit low
//   key_code     out  4  latched key index = row*4 + col
//   key_raw      out  8  latched {col_n, row_n} of the accepted key, 8'hFF when none
//   key_valid    out  1  one-cycle pulse when a press is accepted
//   key_release  out  1  one-cycle pulse when the held key is released
//   key_held     out  1  high from the key_valid cycle until the key_release cycle

module keypad_row_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic [7:0] key_raw,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic [DW-1:0] dwell;
    logic [1:0]    row_idx;
    logic          sample;
    logic          eval;

    logic [2:0]    cur_zeros;
    logic [1:0]    cur_col;
    logic [2:0]    base_zeros;
    logic [2:0]    zero_sum;
    logic [1:0]    scan_zeros;
    logic [3:0]    scan_key;
    logic [1:0]    acc_zeros;
    logic [3:0]    acc_key;

    state_t        state, state_nx;
    logic [3:0]    cand, cand_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] rcnt, rcnt_nx;
    logic [3:0]    code_nx;
    logic [7:0]    raw_nx;
    logic          valid_nx;
    logic          release_nx;
    logic          held_nx;
    logic          do_accept;
    logic          do_release;

    // Active-low {col,row} byte for a key index.
    function automatic logic [7:0] raw_of(input logic [3:0] k);
        logic [3:0] c;
        logic [3:0] r;
        c = ~(4'b0001 << k[1:0]);
        r = ~(4'b0001 << k[3:2]);
        return {c, r};
    endfunction

    // Two-flop synchroniser on the asynchronous column returns; idles at
    // all-ones so a reset never looks like a pressed key.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    assign sample = (dwell == DWELL_LAST);
    assign eval   = sample && (row_idx == 2'd3);

    // Row dwell counter and strobe rotation. row_n is kept as its own register
    // (rotated alongside row_idx) so the strobes never glitch.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dwell   <= '0;
            row_idx <= 2'd0;
            row_n   <= 4'b1110;
        end else if (sample) begin
            dwell   <= '0;
            row_idx <= row_idx + 2'd1;
            row_n   <= {row_n[2:0], row_n[3]};
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Count the zero columns of the current row and remember where a lone
    // zero sits; only meaningful when exactly one bit is low.
    always_comb begin
        cur_zeros = 3'd0;
        cur_col   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col_s[i]) begin
                cur_zeros = cur_zeros + 3'd1;
                cur_col   = 2'(i);
            end
        end
    end

    // Fold this row's sample into the running per-scan tally. The tally
    // saturates at 2, which is all the classifier needs to tell SINGLE from
    // MULTI. Row 0 starts a fresh scan, so the stale tally is ignored there.
    always_comb begin
        base_zeros = (row_idx == 2'd0) ? 3'd0 : {1'b0, acc_zeros};
        zero_sum   = base_zeros + cur_zeros;
        scan_zeros = (zero_sum >= 3'd2) ? 2'd2 : zero_sum[1:0];
        scan_key   = (cur_zeros == 3'd1) ? {row_idx, cur_col} : acc_key;
    end

    // Per-scan tally register, updated once per row at the sample cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            acc_zeros <= 2'd0;
            acc_key   <= 4'd0;
        end else if (sample) begin
            acc_zeros <= scan_zeros;
            acc_key   <= scan_key;
        end
    end

    // Debounce / hold FSM state and the latched outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cand        <= 4'd0;
            cnt         <= '0;
            rcnt        <= '0;
            key_code    <= 4'd0;
            key_raw     <= 8'hFF;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            state       <= state_nx;
            cand        <= cand_nx;
            cnt         <= cnt_nx;
            rcnt        <= rcnt_nx;
            key_code    <= code_nx;
            key_raw     <= raw_nx;
            key_valid   <= valid_nx;
            key_release <= release_nx;
            key_held    <= held_nx;
        end
    end

    // Next-state logic, evaluated only at the row-3 sample cycle when the
    // scan's candidate is complete. Acceptance and release are folded in
    // afterwards so DEBOUNCE_SCANS = 1 can skip the intermediate states.
    always_comb begin
        state_nx   = state;
        cand_nx    = cand;
        cnt_nx     = cnt;
        rcnt_nx    = rcnt;
        code_nx    = key_code;
        raw_nx     = key_raw;
        valid_nx   = 1'b0;
        release_nx = 1'b0;
        held_nx    = key_held;
        do_accept  = 1'b0;
        do_release = 1'b0;

        if (eval) begin
            case (state)
                IDLE: begin
                    if (scan_zeros == 2'd1) begin
                        cand_nx  = scan_key;
                        cnt_nx   = CNT_ONE;
                        state_nx = DEBOUNCE;
                        if (CNT_ONE == DEB_TARGET) do_accept = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (scan_zeros == 2'd1) begin
                        if (scan_key == cand) begin
                            cnt_nx = cnt + CNT_ONE;
                        end else begin
                            cand_nx = scan_key;
                            cnt_nx  = CNT_ONE;
                        end
                        if (cnt_nx == DEB_TARGET) do_accept = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                PRESSED: begin
                    if (scan_zeros == 2'd0) begin
                        rcnt_nx  = CNT_ONE;
                        state_nx = RELEASE;
                        if (CNT_ONE == DEB_TARGET) do_release = 1'b1;
                    end
                end
                RELEASE: begin
                    if (scan_zeros == 2'd0) begin
                        rcnt_nx = rcnt + CNT_ONE;
                        if (rcnt_nx == DEB_TARGET) do_release = 1'b1;
                    end else if ((scan_zeros == 2'd1) && (scan_key == cand)) begin
                        state_nx = PRESSED;
                        rcnt_nx  = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        if (do_accept) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
            code_nx  = cand_nx;
            raw_nx   = raw_of(cand_nx);
            valid_nx = 1'b1;
            held_nx  = 1'b1;
        end

        if (do_release) begin
            state_nx   = IDLE;
            rcnt_nx    = '0;
            raw_nx     = 8'hFF;
            release_nx = 1'b1;
            held_nx    = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_row_scanner.sv
// tb_keypad_row_scanner
// Self-checking bench for keypad_row_scanner with SCAN_DIV = 4 and
// DEBOUNCE_SCANS = 2 (one full scan = 16 cycles). A keypad model turns a
// 16-bit "keys pressed" mask plus the current row strobe into col_n, and a
// scan-level reference model predicts the events and latched outputs.

module tb_keypad_row_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic [7:0] key_raw;
    logic       key_valid;
    logic       key_release;
    logic       key_held;

    logic [15:0] mask = 16'h0000;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, kept at the level of whole scans.
    logic       m_held;
    logic [3:0] m_code;
    logic [7:0] m_raw;
    int         m_streak;
    int         m_streak_key;
    int         m_quiet;
    logic       exp_valid;
    logic       exp_release;

    keypad_row_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .col_n      (col_n),
        .row_n      (row_n),
        .key_code   (key_code),
        .key_raw    (key_raw),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_held   (key_held)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Physical keypad: a pressed key shorts its row strobe onto its column.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (row_n[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (mask[r*4+c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] raw_for(input int k);
        logic [3:0] c;
        logic [3:0] r;
        c = 4'hF;
        r = 4'hF;
        c[k % 4] = 1'b0;
        r[k / 4] = 1'b0;
        return {c, r};
    endfunction

    task automatic model_reset();
        m_held       = 1'b0;
        m_code       = 4'd0;
        m_raw        = 8'hFF;
        m_streak     = 0;
        m_streak_key = 0;
        m_quiet      = 0;
        exp_valid    = 1'b0;
        exp_release  = 1'b0;
    endtask

    // One scan of the keypad: a key is accepted after DEB consecutive scans
    // showing it alone; a held key is released after DEB consecutive empty
    // scans, and seeing it alone again cancels a pending release.
    task automatic model_scan(input logic [15:0] m);
        int nbits;
        int k;
        nbits       = 0;
        k           = 0;
        exp_valid   = 1'b0;
        exp_release = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                nbits++;
                k = i;
            end
        end
        if (!m_held) begin
            if (nbits == 1) begin
                if (m_streak > 0 && k == m_streak_key) m_streak++;
                else begin
                    m_streak_key = k;
                    m_streak     = 1;
                end
                if (m_streak == DEB) begin
                    m_held    = 1'b1;
                    m_code    = 4'(k);
                    m_raw     = raw_for(k);
                    exp_valid = 1'b1;
                    m_streak  = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            if (nbits == 0) begin
                m_quiet++;
                if (m_quiet == DEB) begin
                    m_held      = 1'b0;
                    m_raw       = 8'hFF;
                    exp_release = 1'b1;
                    m_quiet     = 0;
                end
            end else if (nbits == 1 && 4'(k) == m_code) begin
                m_quiet = 0;
            end
        end
    endtask

    // Hold reset across a few edges and release it 1 time unit after a
    // rising edge, so the bench sits at the start of cycle 0 of scan 0.
    task automatic reset_dut();
        reset = 1'b1;
        mask  = 16'h0000;
        repeat (2) @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Apply one mask for a whole scan starting at a scan boundary. The
    // scan's event, if any, is visible in the first cycle of the next scan
    // (the 16th sample); no pulse may appear before that.
    task automatic run_scan(input logic [15:0] m, input string tag);
        int early;
        early = 0;
        mask  = m;
        model_scan(m);
        for (int i = 1; i <= SCAN_CYC; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (i < SCAN_CYC && (key_valid || key_release)) early++;
        end
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("[TB] FAIL %s early_pulse: got %0d pulse cycles, expected 0", tag, early);
        end
        vectors++;
        if (row_n !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL %s scan_align row_n: got %b expected 1110", tag, row_n);
        end
        vectors++;
        if (key_valid !== exp_valid) begin
            miscompares++;
            $display("[TB] FAIL %s key_valid: got %b expected %b", tag, key_valid, exp_valid);
        end
        vectors++;
        if (key_release !== exp_release) begin
            miscompares++;
            $display("[TB] FAIL %s key_release: got %b expected %b", tag, key_release, exp_release);
        end
        vectors++;
        if (key_held !== m_held) begin
            miscompares++;
            $display("[TB] FAIL %s key_held: got %b expected %b", tag, key_held, m_held);
        end
        vectors++;
        if (key_raw !== m_raw) begin
            miscompares++;
            $display("[TB] FAIL %s key_raw: got %h expected %h", tag, key_raw, m_raw);
        end
        vectors++;
        if (key_code !== m_code) begin
            miscompares++;
            $display("[TB] FAIL %s key_code: got %0d expected %0d", tag, key_code, m_code);
        end
    endtask

    // Outputs while reset is held, then the row strobe walk through one full
    // scan including the wrap back to row 0.
    task automatic test_reset();
        logic [3:0] exp_row;
        reset = 1'b1;
        mask  = 16'h0000;
        repeat (3) @(posedge CLOCK_50);
        #1;
        vectors++;
        if ({row_n, key_code, key_raw, key_valid, key_release, key_held} !==
            {4'b1110, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got row_n=%b code=%0d raw=%h v=%b r=%b h=%b expected 1110/0/ff/0/0/0",
                     row_n, key_code, key_raw, key_valid, key_release, key_held);
        end
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i <= SCAN_CYC; i++) begin
            if (i > 0) begin
                @(posedge CLOCK_50);
                #1;
            end
            exp_row = 4'hF;
            exp_row[(i / SCAN_DIV) % 4] = 1'b0;
            vectors++;
            if (row_n !== exp_row) begin
                miscompares++;
                $display("[TB] FAIL row_walk cycle %0d: got %b expected %b", i, row_n, exp_row);
            end
        end
        vectors++;
        if ({key_code, key_raw, key_valid, key_release, key_held} !==
            {4'd0, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs: got code=%0d raw=%h v=%b r=%b h=%b expected 0/ff/0/0/0",
                     key_code, key_raw, key_valid, key_release, key_held);
        end
    endtask

    task automatic test_press();
        reset_dut();
        run_scan(16'h0040, "press_s1");
        run_scan(16'h0040, "press_s2");
        run_scan(16'h0040, "press_s3");
    endtask

    task automatic test_bounce();
        reset_dut();
        run_scan(16'h0040, "bounce_s1");
        run_scan(16'h0000, "bounce_gap1");
        run_scan(16'h0000, "bounce_gap2");
        run_scan(16'h0040, "bounce_re1");
        run_scan(16'h0040, "bounce_re2");
    endtask

    task automatic test_release();
        reset_dut();
        run_scan(16'h0040, "rel_p1");
        run_scan(16'h0040, "rel_p2");
        run_scan(16'h0000, "rel_blip");
        run_scan(16'h0040, "rel_repress");
        run_scan(16'h0040, "rel_hold");
        run_scan(16'h0000, "rel_q1");
        run_scan(16'h0000, "rel_q2");
        run_scan(16'h0000, "rel_q3");
    endtask

    task automatic test_multi();
        reset_dut();
        run_scan(16'h8001, "multi_a");
        run_scan(16'h8001, "multi_b");
        run_scan(16'h8001, "multi_c");
        run_scan(16'h0008, "k3_p1");
        run_scan(16'h0008, "k3_p2");
        run_scan(16'h1008, "k3_k12_a");
        run_scan(16'h1008, "k3_k12_b");
        run_scan(16'h1000, "k12_only");
        run_scan(16'h0000, "k3_q1");
        run_scan(16'h0000, "k3_q2");
    endtask

    // Reset asserted between clock edges must clear the outputs at once.
    task automatic test_async_reset();
        reset_dut();
        run_scan(16'h0040, "ar_deb");
        repeat (7) @(posedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({row_n, key_code, key_raw, key_valid, key_release, key_held} !==
            {4'b1110, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset_debounce: got row_n=%b code=%0d raw=%h v=%b r=%b h=%b",
                     row_n, key_code, key_raw, key_valid, key_release, key_held);
        end
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        model_reset();
        run_scan(16'h0040, "ar_p1");
        run_scan(16'h0040, "ar_p2");
        repeat (5) @(posedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({row_n, key_code, key_raw, key_valid, key_release, key_held} !==
            {4'b1110, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset_pressed: got row_n=%b code=%0d raw=%h v=%b r=%b h=%b",
                     row_n, key_code, key_raw, key_valid, key_release, key_held);
        end
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        model_reset();
        run_scan(16'h0000, "ar_q1");
        run_scan(16'h0000, "ar_q2");
        run_scan(16'h0000, "ar_q3");
    endtask

    // Random mix of holding, releasing, single keys and chords.
    task automatic test_random();
        logic [15:0] prev;
        logic [15:0] m;
        int          sel;
        reset_dut();
        prev = 16'h0000;
        for (int s = 0; s < 48; s++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      m = prev;
            else if (sel < 6) m = 16'h0000;
            else if (sel < 9) m = 16'h0001 << $urandom_range(0, 15);
            else              m = (16'h0001 << $urandom_range(0, 15)) |
                                  (16'h0001 << $urandom_range(0, 15));
            run_scan(m, $sformatf("rand_%0d", s));
            prev = m;
        end
    endtask

    initial begin
        $display("[TB] keypad_row_scanner bench start");
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_multi();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
